trace_window_controller: RTL and testbench
==========================================

# trace_window_controller

Sequences capture of the instruction trace around the trace filter. Software arms it with start/stop trigger PCs and an item budget. Once the start PC retires, it captures every instruction the filter does not drop into a small FIFO that feeds the downstream trace sink with a valid/ready handshake. It stops on the stop PC or when the budget is spent, then drains the FIFO and returns to idle.

## Interface
- PC_WIDTH, 64, width of program counter and config data
- FIFO_DEPTH, 4, capture FIFO entries; power of two, ≥2
- CNT_WIDTH, 32, width of budget, captured and overflow counters
- clk  in  1  single clock; everything rising-edge
- rst  in  1  reset; synchronous and active-high
- cfg_wr  in  1  config write strobe
- cfg_addr  in  2  0 start PC, 1 stop PC, 2 item budget, 3 control
- cfg_wdata  in  PC_WIDTH  write data; control reg: bit0 arm, bit1 abort
- pc_valid  in  1  retired-instruction strobe
- pc  in  PC_WIDTH  PC of retired instruction
- drop_instr  in  1  trace filter decision for the current instruction; 1 = drop
- m_valid  out  1  FIFO head valid
- m_pc  out  PC_WIDTH  FIFO head PC
- m_ready  in  1  downstream accepts head
- state  out  2  0 IDLE, 1 ARMED, 2 ACTIVE, 3 DRAIN
- captured_count  out  CNT_WIDTH  items pushed since last arm
- overflow_count  out  CNT_WIDTH  items lost to a full FIFO since last arm; saturates at all-ones

## Operation
- Registers for start PC, stop PC and budget are written only in IDLE. Writes in other states are ignored. Budget uses cfg_wdata[CNT_WIDTH-1:0]. Budget 0 = unlimited.
- Push condition: a capture event with FIFO not full, or FIFO full with a pop in the same cycle. Otherwise the event increments overflow_count.
- IDLE:
  - A control write with bit0=1 goes to ARMED.
  - The same write clears captured_count and overflow_count.
  - An arm and an abort in the same write is treated as an abort, so the block stays IDLE.
- ARMED:
  - pc_valid && pc==start_pc goes to ACTIVE.
  - That instruction is always a capture event, regardless of drop_instr.
  - Stop PC is not checked in ARMED.
- ACTIVE:
  - Capture event when pc_valid && !drop_instr.
  - A stop-PC instruction (pc_valid && pc==stop_pc) is always a capture event and goes to DRAIN.
  - If the budget is nonzero and a push makes captured_count equal the budget, go to DRAIN.
- DRAIN:
  - No captures.
  - Go to IDLE on the cycle after the FIFO is empty with no push pending.
- Abort (control bit1=1) in ARMED or ACTIVE goes to DRAIN. A capture event in the same cycle is discarded.
- FIFO:
  - m_valid = !empty; m_pc = head.
  - Pop when m_valid && m_ready.
  - Order is preserved.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits.
- captured_count counts pushes only and holds its value through DRAIN and IDLE until the next arm.

## Timing
- Reset values: state IDLE, FIFO empty, m_valid 0, m_pc 0, all counters 0, config regs 0.
- rst overrides everything, including mid-capture with a non-empty FIFO. FIFO contents are discarded.
- Push at edge N: m_valid is high from cycle N+1. No combinational path from pc_valid to m_valid.
- m_pc is stable while m_valid && !m_ready.
- State transitions take effect on the edge following their condition.
- Budget-reached and stop-PC in the same cycle: single transition to DRAIN; the item is pushed once.
- Overflow increment and budget check use the same-cycle push result. Overflowed items do not count toward the budget.

## Test plan
- **Basic window:** start=0x1000, stop=0x1010, budget=0; arm; retire 0x0FFC, 0x1000, 0x1004 (drop=1), 0x1008 (drop=0), 0x1010 (drop=1); m_ready=1 → outputs 0x1000, 0x1008, 0x1010 in order; state ARMED→ACTIVE→DRAIN→IDLE; captured_count=3.
- **Budget:** budget=2, start=0x2000; retire 0x2000, 0x2004, 0x2008, all drop=0 → only 0x2000 and 0x2004 output; DRAIN entered the edge after the second push; captured_count=2.
- **Overflow:** FIFO_DEPTH=4, m_ready=0, six capture events → 4 stored, overflow_count=2. Then raise m_ready → 4 items drain, then IDLE.
- **Full with simultaneous pop:** FIFO full, m_ready=1 and a capture event in the same cycle → push accepted, overflow_count unchanged, occupancy stays 4.
- **Abort and config locking:** abort while ACTIVE with 2 items queued → DRAIN, a same-cycle capture is dropped, 2 items output, then IDLE. A start-PC write during ACTIVE is ignored; read back via the next capture.
- **Reset mid-capture:** assert rst in ACTIVE with 3 items queued → next cycle m_valid=0, state=IDLE, counters 0.

Source files
------------

// File: rtl/trace_window_controller.sv
// Trace window sequencer: arms on a start PC, captures filtered retirements into a
// small FIFO, stops on a stop PC, budget or abort, then drains to the trace sink.
module trace_window_controller #(
    parameter int PC_WIDTH   = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr,
    input  logic [1:0]           cfg_addr,
    input  logic [PC_WIDTH-1:0]  cfg_wdata,
    input  logic                 pc_valid,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 drop_instr,
    output logic                 m_valid,
    output logic [PC_WIDTH-1:0]  m_pc,
    input  logic                 m_ready,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] captured_count,
    output logic [CNT_WIDTH-1:0] overflow_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DRAIN} state_t;

    state_t               state_q;
    logic [PC_WIDTH-1:0]  start_q, stop_q;
    logic [CNT_WIDTH-1:0] budget_q;
    logic [PC_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          occ_q, occ_d;
    logic [CNT_WIDTH-1:0] cap_q, cap_d, ovf_q, ovf_d;

    logic ctrl_wr, arm, abort, start_hit, stop_hit;
    logic cap_ev, full, empty, pop, push, budget_hit;

    assign ctrl_wr   = cfg_wr && (cfg_addr == 2'd3);
    assign arm       = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign abort     = ctrl_wr && cfg_wdata[1];
    assign start_hit = pc_valid && (pc == start_q);
    assign stop_hit  = pc_valid && (pc == stop_q);

    // Abort wins over any capture in the same cycle.
    always_comb begin
        cap_ev = 1'b0;
        case (state_q)
            S_ARMED:  cap_ev = start_hit && !abort;
            S_ACTIVE: cap_ev = !abort && pc_valid && (!drop_instr || stop_hit);
            default:  cap_ev = 1'b0;
        endcase
    end

    assign full  = (occ_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (occ_q == '0);
    assign pop   = !empty && m_ready;
    assign push  = cap_ev && (!full || pop);
    assign occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    assign cap_d = cap_q + CNT_WIDTH'(push);
    assign ovf_d = (cap_ev && !push && (ovf_q != '1)) ? ovf_q + CNT_WIDTH'(1) : ovf_q;
    // Only accepted items count toward the budget.
    assign budget_hit = push && (budget_q != '0) && (cap_d == budget_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            budget_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cap_q    <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (state_q == S_IDLE && cfg_wr) begin
                case (cfg_addr)
                    2'd0:    start_q  <= cfg_wdata;
                    2'd1:    stop_q   <= cfg_wdata;
                    2'd2:    budget_q <= cfg_wdata[CNT_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (push) begin
                mem_q[wr_ptr_q] <= pc;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_d;
            if (state_q == S_IDLE && arm) begin
                cap_q <= '0;
                ovf_q <= '0;
            end else begin
                cap_q <= cap_d;
                ovf_q <= ovf_d;
            end
            case (state_q)
                S_IDLE:   if (arm) state_q <= S_ARMED;
                S_ARMED: begin
                    if (abort)          state_q <= S_DRAIN;
                    else if (start_hit) state_q <= budget_hit ? S_DRAIN : S_ACTIVE;
                end
                S_ACTIVE: if (abort || stop_hit || budget_hit) state_q <= S_DRAIN;
                S_DRAIN:  if (empty) state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign m_valid        = !empty;
    assign m_pc           = mem_q[rd_ptr_q];
    assign state          = state_q;
    assign captured_count = cap_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_trace_window_controller.sv
// Bench for trace_window_controller: directed table, corner sequences and random
// traffic, all compared against a queue-based reference model.
module tb_trace_window_controller;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, cfg_wr, pc_valid, drop_instr, m_ready, m_valid;
    logic [1:0]  cfg_addr, state;
    logic [63:0] cfg_wdata, pc, m_pc;
    logic [31:0] captured_count, overflow_count;

    trace_window_controller #(.PC_WIDTH(64), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pc_valid(pc_valid), .pc(pc), .drop_instr(drop_instr),
        .m_valid(m_valid), .m_pc(m_pc), .m_ready(m_ready), .state(state),
        .captured_count(captured_count), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: window state as 0..3, FIFO as a queue of PCs.
    int          md_state;
    logic [63:0] md_q[$];
    logic [31:0] md_cap, md_ovf, md_budget;
    logic [63:0] md_start, md_stop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, ctl, marm, mabort, cap, pushed, clr;
        int ns;
        if (rst) begin
            md_state = 0; md_q.delete(); md_cap = 0; md_ovf = 0;
            md_start = 0; md_stop = 0; md_budget = 0;
            return;
        end
        pop    = (md_q.size() > 0) && m_ready;
        ctl    = cfg_wr && cfg_addr == 2'd3;
        marm   = ctl && cfg_wdata[0] && !cfg_wdata[1];
        mabort = ctl && cfg_wdata[1];
        cap = 0; clr = 0; ns = md_state;
        case (md_state)
            0: begin
                if (cfg_wr && cfg_addr == 2'd0) md_start  = cfg_wdata;
                if (cfg_wr && cfg_addr == 2'd1) md_stop   = cfg_wdata;
                if (cfg_wr && cfg_addr == 2'd2) md_budget = cfg_wdata[31:0];
                if (marm) begin ns = 1; clr = 1; end
            end
            1: if (mabort) ns = 3;
               else if (pc_valid && pc == md_start) begin cap = 1; ns = 2; end
            2: if (mabort) ns = 3;
               else if (pc_valid) begin
                   if (pc == md_stop) begin cap = 1; ns = 3; end
                   else if (!drop_instr) cap = 1;
               end
            default: if (md_q.size() == 0) ns = 0;
        endcase
        pushed = cap && (md_q.size() < DEPTH || pop);
        if (pop) void'(md_q.pop_front());
        if (pushed) begin
            md_q.push_back(pc);
            md_cap++;
            if (md_budget != 0 && md_cap == md_budget) ns = 3;
        end
        if (cap && !pushed && md_ovf != 32'hFFFF_FFFF) md_ovf++;
        if (clr) begin md_cap = 0; md_ovf = 0; end
        md_state = ns;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 64'(state), 64'(md_state));
        chk("m_valid", 64'(m_valid), 64'(md_q.size() > 0));
        if (md_q.size() > 0) chk("m_pc", m_pc, md_q[0]);
        chk("captured_count", 64'(captured_count), 64'(md_cap));
        chk("overflow_count", 64'(overflow_count), 64'(md_ovf));
    endtask

    task automatic quiet();
        cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; pc_valid = 0; pc = 0; drop_instr = 0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [63:0] d);
        quiet(); cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
        step(); quiet();
    endtask

    task automatic retire(input logic [63:0] p, input bit dr);
        quiet(); pc_valid = 1; pc = p; drop_instr = dr;
        step(); quiet();
    endtask

    task automatic to_idle(input string name);
        int n = 0;
        quiet();
        while (state != 2'd0 && n < 50) begin step(); n++; end
        chk(name, 64'(state), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        bit [1:0]    addr;
        logic [63:0] wdata;
        bit          pv;
        logic [63:0] p;
        bit          drop;
        int          st;
        bit          vld;
        logic [63:0] mpc;
        int          cap;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 2'd0, 64'h1000, 0, 64'h0,    0, 0, 0, 64'h0,    0};
        tbl[1]  = '{1, 2'd1, 64'h1010, 0, 64'h0,    0, 0, 0, 64'h0,    0};
        tbl[2]  = '{1, 2'd2, 64'h0,    0, 64'h0,    0, 0, 0, 64'h0,    0};
        tbl[3]  = '{1, 2'd3, 64'h1,    0, 64'h0,    0, 1, 0, 64'h0,    0};
        tbl[4]  = '{0, 2'd0, 64'h0,    1, 64'h0FFC, 0, 1, 0, 64'h0,    0};
        tbl[5]  = '{0, 2'd0, 64'h0,    1, 64'h1000, 1, 2, 1, 64'h1000, 1};
        tbl[6]  = '{0, 2'd0, 64'h0,    1, 64'h1004, 1, 2, 0, 64'h0,    1};
        tbl[7]  = '{0, 2'd0, 64'h0,    1, 64'h1008, 0, 2, 1, 64'h1008, 2};
        tbl[8]  = '{0, 2'd0, 64'h0,    1, 64'h1010, 1, 3, 1, 64'h1010, 3};
        tbl[9]  = '{0, 2'd0, 64'h0,    0, 64'h0,    0, 3, 0, 64'h0,    3};
        tbl[10] = '{0, 2'd0, 64'h0,    0, 64'h0,    0, 0, 0, 64'h0,    3};

        quiet(); m_ready = 0; rst = 1;
        step(); step();
        rst = 0;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_m_pc", m_pc, 64'd0);
        chk("reset_counts", 64'({captured_count, overflow_count}), 64'd0);

        // Basic window from the table.
        m_ready = 1;
        for (int i = 0; i < 11; i++) begin
            cfg_wr = tbl[i].wr; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
            pc_valid = tbl[i].pv; pc = tbl[i].p; drop_instr = tbl[i].drop;
            step();
            chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_valid", i), 64'(m_valid), 64'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_m_pc", i), m_pc, tbl[i].mpc);
            chk($sformatf("tbl%0d_cap", i), 64'(captured_count), 64'(tbl[i].cap));
        end
        quiet();

        // Budget of two.
        cfg(2'd0, 64'h2000); cfg(2'd1, 64'hFFFF_0000); cfg(2'd2, 64'd2); cfg(2'd3, 64'd1);
        retire(64'h2000, 0);
        chk("budget_active", 64'(state), 64'd2);
        retire(64'h2004, 0);
        chk("budget_drain", 64'(state), 64'd3);
        chk("budget_head", m_pc, 64'h2004);
        retire(64'h2008, 0);
        to_idle("budget_idle");
        chk("budget_cap", 64'(captured_count), 64'd2);

        // Overflow, then full with a simultaneous pop, then abort and drain.
        m_ready = 0;
        cfg(2'd0, 64'h3000); cfg(2'd1, 64'h3FFF); cfg(2'd2, 64'd0); cfg(2'd3, 64'd1);
        for (int i = 0; i < 6; i++) retire(64'h3000 + 64'(4 * i), 0);
        chk("ovf_count", 64'(overflow_count), 64'd2);
        chk("ovf_cap", 64'(captured_count), 64'd4);
        chk("ovf_head", m_pc, 64'h3000);
        m_ready = 1;
        retire(64'h3018, 0);
        chk("fullpop_ovf", 64'(overflow_count), 64'd2);
        chk("fullpop_head", m_pc, 64'h3004);
        chk("fullpop_occ", 64'(md_q.size()), 64'd4);
        m_ready = 0;
        cfg(2'd3, 64'd2);
        chk("ovf_abort", 64'(state), 64'd3);
        m_ready = 1;
        to_idle("ovf_idle");

        // Abort with same-cycle capture, and start PC locked outside IDLE.
        m_ready = 0;
        cfg(2'd0, 64'h4000); cfg(2'd1, 64'h4FFF); cfg(2'd3, 64'd1);
        retire(64'h4000, 0); retire(64'h4004, 0);
        cfg(2'd0, 64'h5000);
        quiet(); cfg_wr = 1; cfg_addr = 2'd3; cfg_wdata = 64'd2; pc_valid = 1; pc = 64'h4008;
        step(); quiet();
        chk("abort_state", 64'(state), 64'd3);
        chk("abort_cap", 64'(captured_count), 64'd2);
        m_ready = 1;
        to_idle("abort_idle");
        cfg(2'd3, 64'd1);
        retire(64'h5000, 0);
        chk("lock_not_started", 64'(state), 64'd1);
        retire(64'h4000, 0);
        chk("lock_started", 64'(state), 64'd2);

        // Reset with three items queued.
        m_ready = 0;
        retire(64'h4010, 0); retire(64'h4014, 0);
        chk("pre_reset_cap", 64'(captured_count), 64'd3);
        rst = 1; step(); rst = 0;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_cap", 64'(captured_count), 64'd0);
        chk("rst_m_pc", m_pc, 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_wr    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            if (cfg_addr == 2'd3)      cfg_wdata = 64'($urandom_range(0, 3));
            else if (cfg_addr == 2'd2) cfg_wdata = 64'($urandom_range(0, 4));
            else                       cfg_wdata = 64'h100 + 64'(4 * $urandom_range(0, 7));
            pc_valid   = ($urandom_range(0, 3) != 0);
            pc         = 64'h100 + 64'(4 * $urandom_range(0, 7));
            drop_instr = $urandom_range(0, 1) == 1;
            m_ready    = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
